// File: rtl/clk_enables_param_if.sv
// Bundle between the clock-enable generator and the blocks it drives:
// CPU-side controls in, phase strobes and speed status out.
interface clk_enables_param_if;
  logic       CPUContention;
  logic       cpu_hold;
  logic [2:0] cpu_speed;
  logic       clk28en;
  logic       clk14en;
  logic       clk7en;
  logic       clk7en_n;
  logic       clk35en;
  logic       clk35en_n;
  logic       clk175en;
  logic       clkcpu_enable;
  logic [2:0] speed_eff;
  logic       speed_chg;

  modport master (
    output CPUContention, cpu_hold, cpu_speed,
    input  clk28en, clk14en, clk7en, clk7en_n, clk35en, clk35en_n, clk175en,
    input  clkcpu_enable, speed_eff, speed_chg
  );

  modport slave (
    input  CPUContention, cpu_hold, cpu_speed,
    output clk28en, clk14en, clk7en, clk7en_n, clk35en, clk35en_n, clk175en,
    output clkcpu_enable, speed_eff, speed_chg
  );
endinterface

// File: rtl/clk_enables_param.sv
// Spectrum clock-enable generator: one phase counter per 1.75 MHz period,
// decoded into T-state strobes, plus a boundary-synchronised CPU speed select.
module clk_enables_param #(
  parameter int MCLK_PER_T = 8,
  parameter bit TURBO_EN   = 1'b1,
  parameter int MAX_SPEED  = 4
) (
  input  logic               clk,
  input  logic               rst,
  clk_enables_param_if.slave bus
);

  localparam int CW = $clog2(2 * MCLK_PER_T);

  localparam logic [CW-1:0] LAST     = CW'(2 * MCLK_PER_T - 1);
  localparam logic [CW-1:0] MASK_35  = CW'(MCLK_PER_T - 1);
  localparam logic [CW-1:0] MASK_7   = CW'(MCLK_PER_T / 2 - 1);
  localparam logic [CW-1:0] MASK_14  = CW'(MCLK_PER_T / 4 - 1);
  localparam logic [CW-1:0] MASK_28  = CW'(MCLK_PER_T / 8 - 1);
  localparam logic [CW-1:0] PH_35N   = CW'(MCLK_PER_T - 1);
  localparam logic [CW-1:0] PH_7N    = CW'(MCLK_PER_T / 4);
  localparam logic [2:0]    MAX_CODE = 3'(MAX_SPEED);

  if (!(MCLK_PER_T == 8 || MCLK_PER_T == 16)) begin : g_bad_ratio
    $error("clk_enables_param: MCLK_PER_T must be 8 or 16");
  end

  if (MAX_SPEED < 0 || MAX_SPEED > 4) begin : g_bad_ceiling
    $error("clk_enables_param: MAX_SPEED must be in 0..4");
  end

  logic [CW-1:0] cnt;
  logic [2:0]    spd_ask;
  logic [2:0]    spd_req;
  logic [2:0]    speed_eff;
  logic          speed_chg;
  logic          cpu_sel;
  logic          boundary;

  assign boundary = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (boundary) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // With N = 8 the clk28en mask is zero, so that strobe is tied high.
  assign bus.clk175en  = (cnt == '0);
  assign bus.clk35en   = ((cnt & MASK_35) == '0);
  assign bus.clk35en_n = ((cnt & MASK_35) == PH_35N);
  assign bus.clk7en    = ((cnt & MASK_7) == '0);
  assign bus.clk7en_n  = ((cnt & MASK_7) == PH_7N);
  assign bus.clk14en   = ((cnt & MASK_14) == '0);
  assign bus.clk28en   = ((cnt & MASK_28) == '0);

  always_comb begin
    spd_ask = bus.cpu_speed[2] ? 3'd4 : bus.cpu_speed;
    spd_req = 3'd0;
    if (TURBO_EN) begin
      spd_req = (spd_ask > MAX_CODE) ? MAX_CODE : spd_ask;
    end
  end

  // Sampling the request only on the last phase means a new speed always
  // starts at cnt == 0, so no CPU clock is ever cut short by a switch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_eff <= 3'd0;
      speed_chg <= 1'b0;
    end else if (boundary) begin
      speed_eff <= spd_req;
      speed_chg <= (spd_req != speed_eff);
    end else begin
      speed_chg <= 1'b0;
    end
  end

  always_comb begin
    cpu_sel = 1'b0;
    case (speed_eff)
      3'd0:    cpu_sel = bus.clk35en && !bus.CPUContention;
      3'd1:    cpu_sel = bus.clk7en;
      3'd2:    cpu_sel = bus.clk14en;
      3'd3:    cpu_sel = bus.clk28en;
      3'd4:    cpu_sel = 1'b1;
      default: cpu_sel = 1'b0;
    endcase
  end

  assign bus.clkcpu_enable = !bus.cpu_hold && cpu_sel;
  assign bus.speed_eff     = speed_eff;
  assign bus.speed_chg     = speed_chg;

endmodule

// File: tb/tb_clk_enables_param.sv
// Directed bench for clk_enables_param: four instances cover the 28 MHz and
// 56 MHz ratios, a speed ceiling of 1 and turbo disabled.
module tb_clk_enables_param;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  always #5 clk = ~clk;

  clk_enables_param_if if8 ();
  clk_enables_param_if if16 ();
  clk_enables_param_if ifm1 ();
  clk_enables_param_if ift0 ();

  clk_enables_param #(.MCLK_PER_T(8), .TURBO_EN(1'b1), .MAX_SPEED(4)) u8 (
    .clk(clk), .rst(rst), .bus(if8)
  );
  clk_enables_param #(.MCLK_PER_T(16), .TURBO_EN(1'b1), .MAX_SPEED(4)) u16 (
    .clk(clk), .rst(rst), .bus(if16)
  );
  clk_enables_param #(.MCLK_PER_T(8), .TURBO_EN(1'b1), .MAX_SPEED(1)) um1 (
    .clk(clk), .rst(rst), .bus(ifm1)
  );
  clk_enables_param #(.MCLK_PER_T(8), .TURBO_EN(1'b0), .MAX_SPEED(4)) ut0 (
    .clk(clk), .rst(rst), .bus(ift0)
  );

  wire [6:0] s8  = {if8.clk175en, if8.clk35en, if8.clk35en_n, if8.clk7en,
                    if8.clk7en_n, if8.clk14en, if8.clk28en};
  wire [6:0] s16 = {if16.clk175en, if16.clk35en, if16.clk35en_n, if16.clk7en,
                    if16.clk7en_n, if16.clk14en, if16.clk28en};

  // Order: 175, 35, 35_n, 7, 7_n, 14, 28.
  function automatic logic [6:0] exp_strobes(int c, int n);
    return {c == 0, c % n == 0, c % n == n - 1, c % (n / 2) == 0,
            c % (n / 2) == n / 4, c % (n / 4) == 0, c % (n / 8) == 0};
  endfunction

  task automatic tick;
    @(negedge clk);
    step++;
    #1;
  endtask

  task automatic release_reset;
    @(negedge clk);
    rst  = 1'b0;
    step = 0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    {if8.CPUContention, if8.cpu_hold, if8.cpu_speed}    = '0;
    {if16.CPUContention, if16.cpu_hold, if16.cpu_speed} = '0;
    {ifm1.CPUContention, ifm1.cpu_hold, ifm1.cpu_speed} = '0;
    {ift0.CPUContention, ift0.cpu_hold, ift0.cpu_speed} = '0;
    @(negedge clk);
    #1;
    checks++;
    if (s8 !== 7'b1101011) begin
      errors++;
      $display("[TB] FAIL reset_strobes8 got=%b exp=%b", s8, 7'b1101011);
    end
    checks++;
    if (s16 !== 7'b1101011) begin
      errors++;
      $display("[TB] FAIL reset_strobes16 got=%b exp=%b", s16, 7'b1101011);
    end
    checks++;
    if (if8.speed_eff !== 3'd0 || if8.speed_chg !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_speed got=%0d/%b exp=0/0", if8.speed_eff, if8.speed_chg);
    end
    checks++;
    if (if8.clkcpu_enable !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_cpu_en got=%b exp=1", if8.clkcpu_enable);
    end
    if8.CPUContention = 1'b1;
    #1;
    checks++;
    if (if8.clkcpu_enable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_cpu_en_cont got=%b exp=0", if8.clkcpu_enable);
    end
    if8.CPUContention = 1'b0;
    release_reset();
  endtask

  task automatic test_strobes;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) tick();
      checks++;
      if (s8 !== exp_strobes(step % 16, 8)) begin
        errors++;
        $display("[TB] FAIL strobes8 step=%0d got=%b exp=%b", step, s8, exp_strobes(step % 16, 8));
      end
      checks++;
      if (s16 !== exp_strobes(step % 32, 16)) begin
        errors++;
        $display("[TB] FAIL strobes16 step=%0d got=%b exp=%b", step, s16, exp_strobes(step % 32, 16));
      end
      checks++;
      if (if8.clkcpu_enable !== (step % 8 == 0)) begin
        errors++;
        $display("[TB] FAIL cpu_en_speed0 step=%0d got=%b exp=%b", step, if8.clkcpu_enable, step % 8 == 0);
      end
    end
  endtask

  task automatic test_speed_switch;
    int         last_en;
    int         chg_count;
    logic [2:0] exp_eff;
    logic       exp_en;
    while (step % 16 != 3) tick();
    if8.cpu_speed = 3'b010;
    last_en   = 32;
    chg_count = 0;
    for (int i = 0; i < 29; i++) begin
      if (i > 0) tick(); else #1;
      exp_eff = (step >= 48) ? 3'd2 : 3'd0;
      exp_en  = (step >= 48) ? (step % 2 == 0) : (step % 8 == 0);
      if (if8.speed_chg === 1'b1) chg_count++;
      checks++;
      if (if8.speed_eff !== exp_eff) begin
        errors++;
        $display("[TB] FAIL switch_eff step=%0d got=%0d exp=%0d", step, if8.speed_eff, exp_eff);
      end
      checks++;
      if (if8.speed_chg !== (step == 48)) begin
        errors++;
        $display("[TB] FAIL switch_chg step=%0d got=%b exp=%b", step, if8.speed_chg, step == 48);
      end
      checks++;
      if (if8.clkcpu_enable !== exp_en) begin
        errors++;
        $display("[TB] FAIL switch_en step=%0d got=%b exp=%b", step, if8.clkcpu_enable, exp_en);
      end
      if (if8.clkcpu_enable === 1'b1) begin
        checks++;
        if (step - last_en < 2) begin
          errors++;
          $display("[TB] FAIL switch_spacing step=%0d got=%0d exp>=2", step, step - last_en);
        end
        last_en = step;
      end
    end
    checks++;
    if (chg_count != 1) begin
      errors++;
      $display("[TB] FAIL switch_chg_count got=%0d exp=1", chg_count);
    end
  endtask

  task automatic test_clamp;
    int c;
    tick();
    ifm1.cpu_speed = 3'b111;
    ift0.cpu_speed = 3'b011;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) tick(); else #1;
      c = step % 16;
      checks++;
      if (ifm1.speed_eff !== ((step >= 80) ? 3'd1 : 3'd0) || ifm1.speed_chg !== (step == 80)) begin
        errors++;
        $display("[TB] FAIL clamp_max1 step=%0d got=%0d/%b", step, ifm1.speed_eff, ifm1.speed_chg);
      end
      checks++;
      if (ifm1.clkcpu_enable !== ((step >= 80) ? (c % 4 == 0) : (c % 8 == 0))) begin
        errors++;
        $display("[TB] FAIL clamp_max1_en step=%0d got=%b", step, ifm1.clkcpu_enable);
      end
      checks++;
      if (ift0.speed_eff !== 3'd0 || ift0.speed_chg !== 1'b0 || ift0.clkcpu_enable !== (c % 8 == 0)) begin
        errors++;
        $display("[TB] FAIL clamp_noturbo step=%0d got=%0d/%b/%b exp=0/0/%b", step,
                 ift0.speed_eff, ift0.speed_chg, ift0.clkcpu_enable, c % 8 == 0);
      end
    end
  endtask

  task automatic test_contention;
    logic exp8;
    if8.cpu_speed = 3'b000;
    tick();
    if8.CPUContention  = 1'b1;
    ifm1.CPUContention = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) tick();
      if (step == 107) begin
        if8.CPUContention  = 1'b0;
        ifm1.CPUContention = 1'b0;
      end
      #1;
      exp8 = (step > 106) && (step % 8 == 0);
      checks++;
      if (if8.speed_eff !== 3'd0 || if8.clkcpu_enable !== exp8) begin
        errors++;
        $display("[TB] FAIL contention_s0 step=%0d got=%0d/%b exp=0/%b", step,
                 if8.speed_eff, if8.clkcpu_enable, exp8);
      end
      checks++;
      if (ifm1.clkcpu_enable !== (step % 4 == 0)) begin
        errors++;
        $display("[TB] FAIL contention_s1 step=%0d got=%b exp=%b", step, ifm1.clkcpu_enable, step % 4 == 0);
      end
    end
  endtask

  task automatic test_hold;
    logic hold;
    if8.cpu_speed = 3'b100;
    while (step < 127) tick();
    checks++;
    if (if8.speed_eff !== 3'd0) begin
      errors++;
      $display("[TB] FAIL hold_pre_eff got=%0d exp=0", if8.speed_eff);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      hold = (step >= 133) && (step <= 136);
      if8.cpu_hold = hold;
      #1;
      checks++;
      if (if8.speed_eff !== 3'd4 || if8.clkcpu_enable !== !hold) begin
        errors++;
        $display("[TB] FAIL hold_s4 step=%0d got=%0d/%b exp=4/%b", step,
                 if8.speed_eff, if8.clkcpu_enable, !hold);
      end
    end
    if8.cpu_hold = 1'b0;
  endtask

  task automatic test_reset_mid;
    while (step % 16 != 9) tick();
    checks++;
    if (if8.speed_eff !== 3'd4 || if8.clk175en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_pre got=%0d/%b exp=4/0", if8.speed_eff, if8.clk175en);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (s8 !== 7'b1101011 || if8.speed_eff !== 3'd0 || if8.speed_chg !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_async got=%b/%0d/%b exp=1101011/0/0", s8, if8.speed_eff, if8.speed_chg);
    end
    release_reset();
    for (int i = 0; i < 32; i++) begin
      if (i > 0) tick();
      checks++;
      if (s8 !== exp_strobes(step % 16, 8)) begin
        errors++;
        $display("[TB] FAIL midreset_strobes step=%0d got=%b exp=%b", step, s8, exp_strobes(step % 16, 8));
      end
      checks++;
      if (if8.speed_eff !== ((step >= 16) ? 3'd4 : 3'd0)) begin
        errors++;
        $display("[TB] FAIL midreset_eff step=%0d got=%0d", step, if8.speed_eff);
      end
    end
  endtask

  initial begin
    test_reset();
    test_strobes();
    test_speed_switch();
    test_clamp();
    test_contention();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
